// File: rtl/if_fetch_stage_if.sv
// rtl/if_fetch_stage_if.sv - fetch stage bus: EX redirect, hazard hold, imem port, IF/ID outputs
interface if_fetch_stage_if #(
  parameter int CNT_WIDTH = 16
) ();
  logic                 jump;
  logic [31:0]          jump_target;
  logic                 stall;
  logic [31:0]          imem_addr;
  logic [31:0]          imem_rdata;
  logic                 imem_valid;
  logic [31:0]          ifid_pc;
  logic [31:0]          ifid_inst;
  logic                 ifid_valid;
  logic                 flush_idex;
  logic                 misalign_err;
  logic [CNT_WIDTH-1:0] redirect_cnt;

  // master is the fetch stage itself
  modport master (
    input  jump, jump_target, stall, imem_rdata, imem_valid,
    output imem_addr, ifid_pc, ifid_inst, ifid_valid, flush_idex,
           misalign_err, redirect_cnt
  );

  modport slave (
    output jump, jump_target, stall, imem_rdata, imem_valid,
    input  imem_addr, ifid_pc, ifid_inst, ifid_valid, flush_idex,
           misalign_err, redirect_cnt
  );
endinterface

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - RV32I instruction fetch: PC, IF/ID register, EX redirect and squash
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013,
  parameter int          CNT_WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  if_fetch_stage_if.master  bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [31:0]          pc_q, pc_d;
  logic [31:0]          ifid_pc_q, ifid_pc_d;
  logic [31:0]          ifid_inst_q, ifid_inst_d;
  logic                 ifid_valid_q, ifid_valid_d;
  logic                 misalign_q, misalign_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Mode priority: redirect, then hold, then miss, then advance
  always_comb begin
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_valid_d = ifid_valid_q;
    misalign_d   = misalign_q;
    cnt_d        = cnt_q;
    if (bus.jump) begin
      pc_d         = {bus.jump_target[31:2], 2'b00};
      ifid_pc_d    = 32'h0;
      ifid_inst_d  = NOP_INST;
      ifid_valid_d = 1'b0;
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_ONE;
      end
      if (bus.jump_target[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end else if (bus.stall) begin
      pc_d = pc_q;
    end else if (!bus.imem_valid) begin
      ifid_pc_d    = 32'h0;
      ifid_inst_d  = NOP_INST;
      ifid_valid_d = 1'b0;
    end else begin
      pc_d         = pc_q + 32'd4;
      ifid_pc_d    = pc_q;
      ifid_inst_d  = bus.imem_rdata;
      ifid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      ifid_pc_q    <= 32'h0;
      ifid_inst_q  <= NOP_INST;
      ifid_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_valid_q <= ifid_valid_d;
      misalign_q   <= misalign_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.imem_addr    = pc_q;
  assign bus.flush_idex   = bus.jump & ~rst;
  assign bus.ifid_pc      = ifid_pc_q;
  assign bus.ifid_inst    = ifid_inst_q;
  assign bus.ifid_valid   = ifid_valid_q;
  assign bus.misalign_err = misalign_q;
  assign bus.redirect_cnt = cnt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - directed bench for if_fetch_stage (16-bit and 2-bit counter instances)
module tb_if_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  if_fetch_stage_if #(.CNT_WIDTH(16)) bus_a ();
  if_fetch_stage_if #(.CNT_WIDTH(2))  bus_b ();

  if_fetch_stage #(.RESET_PC(32'h0), .NOP_INST(NOP), .CNT_WIDTH(16)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  if_fetch_stage #(.RESET_PC(32'h0), .NOP_INST(NOP), .CNT_WIDTH(2)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                            input logic valid);
    check({tag, ".ifid_pc"},    bus_a.ifid_pc,    pc);
    check({tag, ".ifid_inst"},  bus_a.ifid_inst,  inst);
    check({tag, ".ifid_valid"}, {31'h0, bus_a.ifid_valid}, {31'h0, valid});
  endtask

  logic [31:0] prog [4];
  logic [31:0] tgt_b [5];
  logic [1:0]  cnt_b [5];

  initial begin
    prog[0] = 32'h0050_0093; prog[1] = 32'h0060_0113;
    prog[2] = 32'h0072_8463; prog[3] = 32'h0000_0013;
    tgt_b[0] = 32'h100; tgt_b[1] = 32'h200; tgt_b[2] = 32'h300;
    tgt_b[3] = 32'h400; tgt_b[4] = 32'h500;
    cnt_b[0] = 2'd1; cnt_b[1] = 2'd2; cnt_b[2] = 2'd3; cnt_b[3] = 2'd3; cnt_b[4] = 2'd3;

    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.jump = 1'b0; bus_a.jump_target = 32'h0; bus_a.stall = 1'b0;
    bus_a.imem_rdata = 32'h0; bus_a.imem_valid = 1'b0;
    bus_b.jump = 1'b0; bus_b.jump_target = 32'h0; bus_b.stall = 1'b0;
    bus_b.imem_rdata = 32'h0; bus_b.imem_valid = 1'b0;
    step(); step();
    rst_a = 1'b0; rst_b = 1'b0;
    #1;

    // Reset state
    check("rst.pc", bus_a.imem_addr, 32'h0);
    check_ifid("rst", 32'h0, NOP, 1'b0);
    check("rst.misalign", {31'h0, bus_a.misalign_err}, 32'h0);
    check("rst.cnt", {16'h0, bus_a.redirect_cnt}, 32'h0);
    check("rst.flush", {31'h0, bus_a.flush_idex}, 32'h0);

    // Straight-line fetch of four instructions
    bus_a.imem_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_a.imem_rdata = prog[i];
      #1;
      check($sformatf("adv%0d.addr", i), bus_a.imem_addr, 32'(i * 4));
      step();
      check_ifid($sformatf("adv%0d", i), 32'(i * 4), prog[i], 1'b1);
    end
    check("adv.pc_end", bus_a.imem_addr, 32'h10);

    // Fetch at 0x10, then redirect to 0x8
    bus_a.imem_rdata = 32'hAAAA_0001;
    step();
    check("fetch10.pc", bus_a.imem_addr, 32'h14);
    bus_a.jump = 1'b1; bus_a.jump_target = 32'h8; bus_a.imem_rdata = 32'hDEAD_BEEF;
    #1;
    check("jmp.flush", {31'h0, bus_a.flush_idex}, 32'h1);
    step();
    bus_a.jump = 1'b0;
    #1;
    check("jmp.pc", bus_a.imem_addr, 32'h8);
    check_ifid("jmp.bubble", 32'h0, NOP, 1'b0);
    check("jmp.cnt", {16'h0, bus_a.redirect_cnt}, 32'h1);
    check("jmp.flush_off", {31'h0, bus_a.flush_idex}, 32'h0);
    bus_a.imem_rdata = 32'h1111_0001;
    step();
    check_ifid("jmp.target", 32'h8, 32'h1111_0001, 1'b1);
    check("jmp.pc2", bus_a.imem_addr, 32'hC);

    // Stall three edges at pc=0xC
    bus_a.stall = 1'b1; bus_a.imem_rdata = 32'h2222_0002;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall%0d.pc", i), bus_a.imem_addr, 32'hC);
      check_ifid($sformatf("stall%0d", i), 32'h8, 32'h1111_0001, 1'b1);
    end
    // Jump overrides stall
    bus_a.jump = 1'b1; bus_a.jump_target = 32'h40;
    step();
    bus_a.jump = 1'b0; bus_a.stall = 1'b0;
    check("stalljmp.pc", bus_a.imem_addr, 32'h40);
    check_ifid("stalljmp", 32'h0, NOP, 1'b0);
    check("stalljmp.cnt", {16'h0, bus_a.redirect_cnt}, 32'h2);

    // Fetch miss at pc=0x20
    bus_a.jump = 1'b1; bus_a.jump_target = 32'h20;
    step();
    bus_a.jump = 1'b0; bus_a.imem_valid = 1'b0; bus_a.imem_rdata = 32'h3333_0003;
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("miss%0d.pc", i), bus_a.imem_addr, 32'h20);
      check_ifid($sformatf("miss%0d", i), 32'h0, NOP, 1'b0);
    end
    bus_a.imem_valid = 1'b1; bus_a.imem_rdata = 32'h4444_0004;
    step();
    check_ifid("miss.recover", 32'h20, 32'h4444_0004, 1'b1);
    check("miss.recover.pc", bus_a.imem_addr, 32'h24);
    check("miss.cnt", {16'h0, bus_a.redirect_cnt}, 32'h3);

    // Misaligned target is forced to word alignment and flagged sticky
    bus_a.jump = 1'b1; bus_a.jump_target = 32'h0000_0106;
    step();
    bus_a.jump = 1'b0;
    check("mis.pc", bus_a.imem_addr, 32'h104);
    check("mis.err", {31'h0, bus_a.misalign_err}, 32'h1);
    step(); step();
    check("mis.pc2", bus_a.imem_addr, 32'h10C);
    check("mis.sticky", {31'h0, bus_a.misalign_err}, 32'h1);
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    check("mis.rst.err", {31'h0, bus_a.misalign_err}, 32'h0);
    check("mis.rst.pc", bus_a.imem_addr, 32'h0);
    check("mis.rst.cnt", {16'h0, bus_a.redirect_cnt}, 32'h0);

    // PC wraps from 0xFFFF_FFFC to 0
    bus_a.jump = 1'b1; bus_a.jump_target = 32'hFFFF_FFFC;
    step();
    bus_a.jump = 1'b0; bus_a.imem_rdata = 32'h5555_0005;
    check("wrap.pc0", bus_a.imem_addr, 32'hFFFF_FFFC);
    check("wrap.err", {31'h0, bus_a.misalign_err}, 32'h0);
    step();
    check("wrap.pc1", bus_a.imem_addr, 32'h0);
    check_ifid("wrap", 32'hFFFF_FFFC, 32'h5555_0005, 1'b1);

    // 2-bit counter saturation on back-to-back jumps
    bus_b.imem_valid = 1'b1;
    bus_b.jump = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus_b.jump_target = tgt_b[i];
      step();
      check($sformatf("sat%0d.cnt", i), {30'h0, bus_b.redirect_cnt}, {30'h0, cnt_b[i]});
      check($sformatf("sat%0d.pc", i), bus_b.imem_addr, tgt_b[i]);
    end
    // Reset wins over a simultaneous jump
    rst_b = 1'b1; bus_b.jump_target = 32'h600;
    #1;
    check("rstjmp.flush", {31'h0, bus_b.flush_idex}, 32'h0);
    step();
    rst_b = 1'b0; bus_b.jump = 1'b0;
    check("rstjmp.cnt", {30'h0, bus_b.redirect_cnt}, 32'h0);
    check("rstjmp.pc", bus_b.imem_addr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
